// File: rtl/seq_modulo_pkg.sv
// Shared definitions for the sequential divider/modulo unit.
// Holds the default operand widths and the controller state encoding.
package seq_modulo_pkg;

    localparam int unsigned DW_DEFAULT = 8;
    localparam int unsigned IW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_modulo_pkg

// File: rtl/seq_modulo_sign_extender.sv
// Widens a narrow operand to the full datapath width.
// Ports:
//   in  - IW-bit narrow operand
//   sgn - 1 = sign-extend from bit IW-1, 0 = zero-extend
//   out - DW-bit extended value
module sign_extender #(
    parameter int unsigned IW = 4,
    parameter int unsigned DW = 8
) (
    input  logic [IW-1:0] in,
    input  logic          sgn,
    output logic [DW-1:0] out
);

    logic fill;

    always_comb begin
        fill = sgn & in[IW-1];
        out  = {{(DW-IW){fill}}, in};
    end

endmodule : sign_extender

// File: rtl/seq_modulo.sv
// Sequential divider producing quotient and remainder, one quotient bit
// per cycle via restoring division on operand magnitudes.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - request a new operation (accepted only in IDLE)
//   signed_mode  - 1 = two's-complement operands
//   ext_a        - 1 = dividend is a[IW-1:0] extended to DW bits
//   a, b         - dividend, divisor
//   busy, done   - operation in progress / one-cycle result strobe
//   quo, rem     - quotient and remainder
//   div0         - last operation had a zero divisor
module seq_modulo
    import seq_modulo_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned IW = IW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          signed_mode,
    input  logic          ext_a,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quo,
    output logic [DW-1:0] rem,
    output logic          div0
);

    localparam int unsigned CW = $clog2(DW) + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
    logic [DW-1:0]   acc_q, acc_d;     // partial remainder
    logic [DW-1:0]   dsr_q, dsr_d;     // divisor magnitude
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   quo_q, quo_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            div0_q, div0_d;

    logic [DW-1:0]   ext_val;
    logic [DW-1:0]   dividend;
    logic            a_neg, b_neg;
    logic [DW-1:0]   a_mag, b_mag;
    logic [DW:0]     trial;
    logic            qbit;
    logic [DW-1:0]   acc_next;
    logic [DW-1:0]   q_next;

    sign_extender #(
        .IW (IW),
        .DW (DW)
    ) u_ext (
        .in  (a[IW-1:0]),
        .sgn (signed_mode),
        .out (ext_val)
    );

    // Operand selection and magnitudes for the launch cycle
    always_comb begin
        dividend = ext_a ? ext_val : a;
        a_neg    = signed_mode & dividend[DW-1];
        b_neg    = signed_mode & b[DW-1];
        a_mag    = a_neg ? (DW'(0) - dividend) : dividend;
        b_mag    = b_neg ? (DW'(0) - b) : b;
    end

    // One restoring step; trial needs DW+1 bits because acc may reach dsr-1
    always_comb begin
        trial    = {acc_q, dvd_q[DW-1]};
        qbit     = (trial >= {1'b0, dsr_q});
        acc_next = qbit ? DW'(trial - {1'b0, dsr_q}) : trial[DW-1:0];
        q_next   = {dvd_q[DW-2:0], qbit};
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        acc_d   = acc_q;
        dsr_d   = dsr_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d  = a_mag;
                    dsr_d  = b_mag;
                    acc_d  = '0;
                    cnt_d  = '0;
                    qneg_d = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (b == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend;
                        div0_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        div0_d  = 1'b0;
                    end
                end
            end
            CALC: begin
                acc_d = acc_next;
                dvd_d = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    // Most-negative / -1 wraps naturally through the negation
                    quo_d   = qneg_q ? (DW'(0) - q_next) : q_next;
                    rem_d   = rneg_q ? (DW'(0) - acc_next) : acc_next;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            acc_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            acc_q   <= acc_d;
            dsr_q   <= dsr_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign div0 = div0_q;

endmodule : seq_modulo

// File: tb/tb_seq_modulo.sv
// Directed self-checking bench for seq_modulo (DW=8, IW=4).
module tb_seq_modulo;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          signed_mode;
    logic          ext_a;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] quo;
    logic [DW-1:0] rem;
    logic          div0;

    int errors = 0;
    int checks = 0;

    seq_modulo #(.DW(8), .IW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .ext_a       (ext_a),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quo         (quo),
        .rem         (rem),
        .div0        (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance until done is seen or the budget runs out; lat counts cycles since t0
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic sm, input logic ex,
                         input logic [7:0] eq, input logic [7:0] er, input logic ed);
        int lat;
        a = av; b = bv; signed_mode = sm; ext_a = ex; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        if (bv != 8'd0) check({tag, "_div0clr"}, 32'(div0), 32'd0);
        wait_done(0, lat);
        check({tag, "_lat"}, 32'(lat), (bv == 8'd0) ? 32'd0 : 32'd8);
        check({tag, "_quo"}, 32'(quo), 32'(eq));
        check({tag, "_rem"}, 32'(rem), 32'(er));
        check({tag, "_div0"}, 32'(div0), 32'(ed));
        @(posedge clk); #1;
        check({tag, "_done_end"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold_quo"}, 32'(quo), 32'(eq));
    endtask

    initial begin
        int lat;
        int pulses;
        rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; ext_a = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quo",  32'(quo),  32'd0);
        check("rst_rem",  32'(rem),  32'd0);
        check("rst_div0", 32'(div0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("unsigned",  8'd200, 8'd7,   1'b0, 1'b0, 8'd28,  8'd4,   1'b0);
        do_op("signed",    8'hF9,  8'd3,   1'b1, 1'b0, 8'hFE,  8'hFF,  1'b0);
        do_op("ext_s",     8'h0C,  8'd3,   1'b1, 1'b1, 8'hFF,  8'hFF,  1'b0);
        do_op("ext_u",     8'h0C,  8'd3,   1'b0, 1'b1, 8'd4,   8'd0,   1'b0);
        do_op("div0",      8'd5,   8'd0,   1'b0, 1'b0, 8'hFF,  8'h05,  1'b1);
        do_op("div0_ext",  8'h0C,  8'd0,   1'b1, 1'b1, 8'hFF,  8'hFC,  1'b1);
        do_op("ovf",       8'h80,  8'hFF,  1'b1, 1'b0, 8'h80,  8'h00,  1'b0);
        do_op("u_max",     8'd255, 8'd16,  1'b0, 1'b0, 8'd15,  8'd15,  1'b0);
        do_op("s_pos_neg", 8'd7,   8'hFD,  1'b1, 1'b0, 8'hFE,  8'h01,  1'b0);
        do_op("s_neg_neg", 8'hF8,  8'hFD,  1'b1, 1'b0, 8'h02,  8'hFE,  1'b0);
        do_op("u_big_b",   8'h80,  8'hFF,  1'b0, 1'b0, 8'h00,  8'h80,  1'b0);

        // start pulsed mid-operation must be ignored
        a = 8'd200; b = 8'd7; signed_mode = 1'b0; ext_a = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'd9; b = 8'd2; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, lat);
        check("ign_lat", 32'(lat), 32'd8);
        check("ign_quo", 32'(quo), 32'd28);
        check("ign_rem", 32'(rem), 32'd4);
        @(posedge clk); #1;
        check("ign_idle", 32'(busy), 32'd0);

        // reset mid-CALC aborts; start held during reset is ignored
        a = 8'd100; b = 8'd3; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quo",  32'(quo),  32'd0);
        check("abort_rem",  32'(rem),  32'd0);
        check("abort_div0", 32'(div0), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("abort_quiet", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_modulo

// File: doc/seq_modulo.md
SEQ_MODULO -- requirements
Module: seq_modulo

Interface
REQ-001 The block SHALL have parameter DW, default 8, giving the operand/result width (>=4).
REQ-002 The block SHALL have parameter IW, default 4, giving the narrow-operand width (2 <= IW < DW).
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request a new operation.
REQ-006 The block SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-007 The block SHALL have port ext_a  input  1  1 = dividend is a[IW-1:0] extended to DW bits.
REQ-008 The block SHALL have port a  input  DW  dividend.
REQ-009 The block SHALL have port b  input  DW  divisor (modulus).
REQ-010 The block SHALL have port busy  output  1  high while the operation is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-012 The block SHALL have port quo  output  DW  quotient.
REQ-013 The block SHALL have port rem  output  DW  remainder.
REQ-014 The block SHALL have port div0  output  1  last operation had b == 0.

Function
REQ-015 The FSM SHALL have states IDLE, CALC and DONE; busy SHALL be high in CALC and DONE.
REQ-016 In IDLE with start=1, the block SHALL sample a, b, signed_mode and ext_a at that edge (t0) and enter CALC, or enter DONE if b == 0.
REQ-017 start SHALL be ignored in CALC and DONE; there is no queueing.
REQ-018 Extension SHALL operate as follows: with ext_a=1, the dividend SHALL be sign-extended from bit IW-1 if signed_mode=1, else zero-extended; with ext_a=0, the dividend SHALL be a.
REQ-019 CALC SHALL perform unsigned restoring division on operand magnitudes, one quotient bit per cycle, for exactly DW cycles.
REQ-020 On the DW-th CALC edge (t0+DW), the block SHALL register quo/rem and enter DONE; done SHALL be high during the following cycle only.
REQ-021 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-022 Signed results SHALL be as follows: quotient negated when operand signs differ; remainder takes the dividend's sign; |rem| < |b|.
REQ-023 Signed overflow (most-negative / -1) SHALL give quo = most-negative (wrap) and rem = 0, with no flag.
REQ-024 b == 0 SHALL give quo = all ones, rem = extended dividend and div0 = 1, with done high in the cycle after t0.
REQ-025 div0 SHALL be cleared at the next accepted start with b != 0.
REQ-026 quo, rem and div0 SHALL hold their values until the next accepted operation completes.

Reset
REQ-027 When rst_n=0 at an edge, the block SHALL go to IDLE with busy=0, done=0, quo=0, rem=0 and div0=0.
REQ-028 Reset mid-CALC or mid-DONE SHALL abort the operation with no done pulse.
REQ-029 start SHALL be ignored at any edge where rst_n=0.

Structure
REQ-030 Shared package seq_modulo_pkg SHALL hold the state encoding (IDLE=0, CALC=1, DONE=2) and the default DW/IW constants.
REQ-031 Sub-module sign_extender (parameters IW, DW; inputs in and sgn) SHALL perform the REQ-018 extension combinationally.
REQ-032 The iteration counter SHALL be clog2(DW)+1 bits wide.

Verification (DW=8, IW=4)
REQ-033 Unsigned test: a=200, b=7, start at t0 -> done at cycle after t0+8, quo=28, rem=4, div0=0.
REQ-034 Signed test: a=0xF9 (-7), b=3 -> quo=0xFE (-2), rem=0xFF (-1).
REQ-035 Extension test: ext_a=1, signed_mode=1, a=0x0C, b=3 -> dividend -4, quo=0xFF, rem=0xFF; with signed_mode=0 -> quo=4, rem=0.
REQ-036 Divide-by-zero test: a=5, b=0 -> done in cycle after t0, div0=1, quo=0xFF, rem=0x05.
REQ-037 Overflow test: signed a=0x80, b=0xFF -> quo=0x80, rem=0x00.
REQ-038 Control test: start pulsed at t0+3 is ignored, with the result unchanged; rst_n=0 at t0+4 -> busy=0 next cycle, no done pulse, outputs zero.
